// File: rtl/video_pkg.sv
// Shared types for the video pipeline stages.
// FSM states and the default beat bundle carried between stages.
package video_pkg;

    localparam int PIX_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        PASS,
        PAD,
        DROP
    } state_t;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef struct packed {
        pixel_t data;
        logic   sop;
        logic   eop;
    } beat_t;

endpackage

// File: rtl/video_skid_buffer.sv
// Two-entry Avalon-ST register slice; writer must respect space.
// Source side is registered so downstream ready never reaches upstream ready.
import video_pkg::*;

module video_skid_buffer #(
    parameter type T = beat_t
) (
    input  logic clk,
    input  logic reset,
    input  logic wr_valid,
    input  T     wr_beat,
    output logic space,
    output logic rd_valid,
    input  logic rd_ready,
    output T     rd_beat
);

    logic [1:0] cnt;
    logic       wp;
    logic       rp;
    T           mem [2];
    logic       push;
    logic       pop;

    assign space    = (cnt != 2'd2);
    assign rd_valid = (cnt != 2'd0);
    assign rd_beat  = mem[rp];
    assign push     = wr_valid && space;
    assign pop      = rd_valid && rd_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= 2'd0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (push) begin
                mem[wp] <= wr_beat;
                wp      <= ~wp;
            end
            if (pop) begin
                rp <= ~rp;
            end
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/video_frame_aligner.sv
// Forces every frame to H_RES*V_RES beats by padding or truncating.
// Define FRAME_ALIGNER_STATS_EN to add frame_cnt / err_cnt outputs.
import video_pkg::*;

module video_frame_aligner #(
    parameter int          DATA_W    = 16,
    parameter int          H_RES     = 320,
    parameter int          V_RES     = 240,
    parameter logic [DATA_W-1:0] PAD_COLOR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic [DATA_W-1:0] data_in,
    input  logic              startofpacket_in,
    input  logic              endofpacket_in,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [DATA_W-1:0] data_out,
    output logic              startofpacket_out,
    output logic              endofpacket_out,
    input  logic              clear_err,
    output logic              err_short,
    output logic              err_long,
`ifdef FRAME_ALIGNER_STATS_EN
    output logic [15:0]       frame_cnt,
    output logic [7:0]        err_cnt,
`endif
    output logic              frame_done
);

    localparam int FRAME_PIX = H_RES * V_RES;
    localparam int CW = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_PIX - 1);
    localparam bit ONE_PIX = (FRAME_PIX == 1);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
    } obeat_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] pix_cnt;
    logic [CW-1:0] cnt_n;
    logic          wr;
    obeat_t        wb;
    obeat_t        rb;
    logic          space;
    logic          set_s;
    logic          set_l;
    logic          sop_v;
    logic          last;

    assign sop_v = valid_in && startofpacket_in;
    assign last  = (pix_cnt == LAST);

    always_comb begin
        state_n    = state;
        cnt_n      = pix_cnt;
        ready_out  = 1'b0;
        wr         = 1'b0;
        wb         = '0;
        set_s      = 1'b0;
        set_l      = 1'b0;
        frame_done = 1'b0;
        if (reset) begin
            unique case (state)
                IDLE: begin
                    // Garbage is swallowed; a sop waits only if skid is full.
                    ready_out = space || !sop_v;
                    if (sop_v && space) begin
                        wr      = 1'b1;
                        wb.data = data_in;
                        wb.sop  = 1'b1;
                        wb.eop  = ONE_PIX;
                        cnt_n   = CW'(1);
                        state_n = PASS;
                        if (ONE_PIX) begin
                            frame_done = 1'b1;
                            cnt_n      = '0;
                            state_n    = endofpacket_in ? IDLE : DROP;
                            set_l      = !endofpacket_in;
                        end else if (endofpacket_in) begin
                            state_n = PAD;
                            set_s   = 1'b1;
                        end
                    end
                end
                PASS: begin
                    ready_out = space && !sop_v;
                    if (sop_v) begin
                        state_n = PAD;
                        set_s   = 1'b1;
                    end else if (valid_in && space) begin
                        wr      = 1'b1;
                        wb.data = data_in;
                        wb.eop  = last;
                        cnt_n   = pix_cnt + CW'(1);
                        if (last) begin
                            frame_done = 1'b1;
                            cnt_n      = '0;
                            state_n    = endofpacket_in ? IDLE : DROP;
                            set_l      = !endofpacket_in;
                        end else if (endofpacket_in) begin
                            state_n = PAD;
                            set_s   = 1'b1;
                        end
                    end
                end
                PAD: begin
                    if (space) begin
                        wr      = 1'b1;
                        wb.data = PAD_COLOR;
                        wb.eop  = last;
                        cnt_n   = pix_cnt + CW'(1);
                        if (last) begin
                            frame_done = 1'b1;
                            cnt_n      = '0;
                            state_n    = IDLE;
                        end
                    end
                end
                DROP: begin
                    // A new sop is left on the bus for IDLE to take.
                    ready_out = !sop_v;
                    if (sop_v || (valid_in && endofpacket_in)) begin
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            pix_cnt   <= '0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
        end else begin
            state   <= state_n;
            pix_cnt <= cnt_n;
            if (set_s)          err_short <= 1'b1;
            else if (clear_err) err_short <= 1'b0;
            if (set_l)          err_long <= 1'b1;
            else if (clear_err) err_long <= 1'b0;
        end
    end

`ifdef FRAME_ALIGNER_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (frame_done) frame_cnt <= frame_cnt + 16'd1;
            if (set_s || set_l) begin
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end else if (clear_err) begin
                err_cnt <= '0;
            end
        end
    end
`endif

    video_skid_buffer #(
        .T(obeat_t)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .wr_valid(wr),
        .wr_beat (wb),
        .space   (space),
        .rd_valid(valid_out),
        .rd_ready(ready_in),
        .rd_beat (rb)
    );

    assign data_out          = rb.data;
    assign startofpacket_out = rb.sop;
    assign endofpacket_out   = rb.eop;

endmodule

// File: tb/tb_video_frame_aligner.sv
// Directed bench for video_frame_aligner with a frame-level reference model.
// Outputs are compared against the model on every accepted output beat.
module tb_video_frame_aligner;

    localparam int          FP   = 8;
    localparam logic [15:0] PADC = 16'hF800;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic [15:0] data_in = '0;
    logic        startofpacket_in = 1'b0;
    logic        endofpacket_in = 1'b0;
    logic        valid_out;
    logic        ready_in = 1'b1;
    logic [15:0] data_out;
    logic        startofpacket_out;
    logic        endofpacket_out;
    logic        clear_err = 1'b0;
    logic        err_short;
    logic        err_long;
    logic        frame_done;
`ifdef FRAME_ALIGNER_STATS_EN
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;
`endif

    video_frame_aligner #(
        .DATA_W(16), .H_RES(4), .V_RES(2), .PAD_COLOR(PADC)
    ) dut (
        .clk(clk), .reset(reset),
        .valid_in(valid_in), .ready_out(ready_out), .data_in(data_in),
        .startofpacket_in(startofpacket_in), .endofpacket_in(endofpacket_in),
        .valid_out(valid_out), .ready_in(ready_in), .data_out(data_out),
        .startofpacket_out(startofpacket_out), .endofpacket_out(endofpacket_out),
        .clear_err(clear_err), .err_short(err_short), .err_long(err_long),
`ifdef FRAME_ALIGNER_STATS_EN
        .frame_cnt(frame_cnt), .err_cnt(err_cnt),
`endif
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic        s;
        logic        e;
    } xb_t;

    xb_t exp_q[$];
    int  n_chk = 0;
    int  n_fail = 0;
    int  fd_seen = 0;
    int  exp_frames = 0;
    int  pad_seen = 0;
    bit  exp_short = 0;
    bit  exp_long = 0;
    bit  m_in = 0;
    bit  m_drop = 0;
    int  m_n = 0;
    bit  rnd_bp = 0;
    bit  stall_prev = 0;
    logic [17:0] prev_beat = '0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endfunction

    function automatic void push_exp(logic [15:0] d, logic s, logic e);
        xb_t x;
        x.d = d; x.s = s; x.e = e;
        exp_q.push_back(x);
        if (e) exp_frames++;
    endfunction

    // Fill the open frame out to FP beats with the pad colour.
    function automatic void m_pad();
        while (m_n < FP) begin
            push_exp(PADC, 1'b0, m_n == FP - 1);
            m_n++;
        end
        m_in = 0;
        exp_short = 1;
    endfunction

    function automatic void model_beat(logic [15:0] d, logic s, logic e);
        if (m_in && s) m_pad();
        if (m_in) begin
            push_exp(d, 1'b0, m_n == FP - 1);
            m_n++;
            if (m_n == FP) begin
                m_in = 0;
                if (!e) begin
                    m_drop = 1;
                    exp_long = 1;
                end
            end else if (e) begin
                m_pad();
            end
            return;
        end
        if (m_drop) begin
            if (s) m_drop = 0;
            else begin
                if (e) m_drop = 0;
                return;
            end
        end
        if (s) begin
            push_exp(d, 1'b1, 1'b0);
            m_n = 1;
            m_in = 1;
            if (e) m_pad();
        end
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        m_in = 0; m_drop = 0; m_n = 0;
        exp_short = 0; exp_long = 0;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            ready_in = rnd_bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            if (valid_out && stall_prev)
                chk("stall_stable", {14'd0, data_out, startofpacket_out, endofpacket_out},
                    {14'd0, prev_beat});
            if (frame_done) fd_seen++;
            if (valid_out && ready_in) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_beat: got %h, required none", data_out);
                end else begin
                    xb_t x;
                    x = exp_q.pop_front();
                    chk("out_beat", {14'd0, data_out, startofpacket_out, endofpacket_out},
                        {14'd0, x.d, x.s, x.e});
                end
                if (data_out == PADC) pad_seen++;
            end
            stall_prev = valid_out && !ready_in;
            prev_beat  = {data_out, startofpacket_out, endofpacket_out};
        end else begin
            stall_prev = 0;
        end
    end

    task automatic send(input logic [15:0] d, input logic s, input logic e);
        bit acc;
        int t;
        model_beat(d, s, e);
        #1;
        valid_in = 1'b1; data_in = d;
        startofpacket_in = s; endofpacket_in = e;
        t = 0;
        acc = 0;
        while (!acc && t < 100) begin
            @(negedge clk);
            acc = ready_out;
            @(posedge clk);
            t++;
        end
        if (!acc) chk("send_timeout", 32'(t), 32'd0);
    endtask

    task automatic idle();
        #1;
        valid_in = 1'b0; startofpacket_in = 1'b0; endofpacket_in = 1'b0;
    endtask

    task automatic run_frame(input logic [15:0] base, input int n, input int eop_at);
        for (int i = 0; i < n; i++)
            send(base + 16'(i), i == 0, i + 1 == eop_at);
    endtask

    task automatic drain();
        int t;
        idle();
        t = 0;
        while ((exp_q.size() != 0 || valid_out) && t < 300) begin
            @(posedge clk);
            t++;
        end
        if (t >= 300) chk("drain_timeout", 32'(t), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic start_test();
        fd_seen = 0; exp_frames = 0; pad_seen = 0;
    endtask

    task automatic end_test();
        drain();
        chk("frame_done_cnt", 32'(fd_seen), 32'(exp_frames));
        chk("err_short", {31'd0, err_short}, {31'd0, exp_short});
        chk("err_long", {31'd0, err_long}, {31'd0, exp_long});
        clear_err = 1'b1;
        @(posedge clk); #1;
        clear_err = 1'b0;
        exp_short = 0; exp_long = 0;
        chk("err_cleared", {30'd0, err_short, err_long}, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready_out", {31'd0, ready_out}, 32'd0);
        chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
        chk("rst_data_out", {16'd0, data_out}, 32'd0);
        chk("rst_flags", {27'd0, startofpacket_out, endofpacket_out,
            err_short, err_long, frame_done}, 32'd0);
        reset = 1'b1;
        @(posedge clk);

        // clean frame, one-cycle latency on the first beat
        start_test();
        send(16'h0001, 1'b1, 1'b0);
        #1;
        chk("latency_first", {14'd0, valid_out, data_out, startofpacket_out},
            {14'd0, 1'b1, 16'h0001, 1'b1});
        for (int i = 1; i < 8; i++) send(16'(i + 1), 1'b0, i == 7);
        end_test();
        chk("clean_frames", 32'(fd_seen), 32'd1);

        // short frame
        start_test();
        run_frame(16'h0001, 5, 5);
        drain();
        chk("short_pads", 32'(pad_seen), 32'd3);
        chk("short_flag", {31'd0, err_short}, 32'd1);
        end_test();

        // long frame
        start_test();
        run_frame(16'h0021, 11, 11);
        drain();
        chk("long_flag", {31'd0, err_long}, 32'd1);
        chk("long_frames", 32'(fd_seen), 32'd1);
        end_test();

        // unframed garbage then a proper frame
        start_test();
        send(16'h00AA, 1'b0, 1'b0);
        send(16'h00BB, 1'b0, 1'b1);
        run_frame(16'h0031, 8, 8);
        end_test();
        chk("garbage_frames", 32'(fd_seen), 32'd1);

        // random back-pressure
        start_test();
        rnd_bp = 1;
        run_frame(16'h1000, 8, 8);
        run_frame(16'h2000, 8, 8);
        run_frame(16'h3000, 8, 8);
        idle();
        repeat (40) @(posedge clk);
        rnd_bp = 0;
        end_test();
        chk("bp_frames", 32'(fd_seen), 32'd3);

        // mid-frame sop
        start_test();
        run_frame(16'h0041, 3, 0);
        run_frame(16'h0051, 8, 8);
        drain();
        chk("midsop_pads", 32'(pad_seen), 32'd5);
        chk("midsop_frames", 32'(fd_seen), 32'd2);
        chk("midsop_short", {31'd0, err_short}, 32'd1);

        // asynchronous reset in the middle of a frame
        start_test();
        run_frame(16'h0061, 3, 0);
        idle();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("arst_outputs", {26'd0, valid_out, ready_out, startofpacket_out,
            endofpacket_out, err_short, err_long}, 32'd0);
        chk("arst_data", {16'd0, data_out}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        start_test();
        run_frame(16'h0071, 8, 8);
        end_test();
        chk("post_rst_frames", 32'(fd_seen), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/video_frame_aligner.md
Name: video_frame_aligner

Overview:
Avalon-ST video stage directly downstream of the video effects IP source port, feeding the display/DMA sink. Guarantees every frame emitted is exactly H_RES*V_RES beats, sop on the first beat, eop on the last. Short frames are padded with a constant colour; long frames are truncated. Output is decoupled by a 2-entry skid buffer.

Parameters:
DATA_W, 16, pixel width (RGB565)
H_RES, 320, pixels per line
V_RES, 240, lines per frame
PAD_COLOR, 16'h0000, pixel value inserted when padding short frames

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
valid_in  in  1  sink valid
ready_out  out  1  sink ready
data_in  in  DATA_W  sink pixel
startofpacket_in  in  1  sink sop
endofpacket_in  in  1  sink eop
valid_out  out  1  source valid
ready_in  in  1  source ready from downstream
data_out  out  DATA_W  source pixel
startofpacket_out  out  1  source sop
endofpacket_out  out  1  source eop
clear_err  in  1  synchronous clear of sticky error flags
err_short  out  1  sticky: a frame was padded
err_long  out  1  sticky: a frame was truncated
frame_done  out  1  one-cycle pulse when a frame's eop beat is written to the skid buffer

Behaviour:
- Reset (reset=0, async): state IDLE, pix_cnt=0, skid empty; valid_out, sop/eop_out, data_out, err_short, err_long, frame_done all 0; ready_out=0 while reset low.
- FRAME_PIX = H_RES*V_RES; pix_cnt width $clog2(FRAME_PIX); counts beats written to skid in current frame.
- Sink beat accepted when valid_in && ready_out. space = skid not full.
- Latency: beat accepted in cycle N appears on valid_out in N+1 when skid empty and ready_in=1.
- Source obeys Avalon-ST readyLatency 0: data/sop/eop held stable while valid_out && !ready_in.
- States:
  IDLE: ready_out=1 (discard). On accepted beat with sop_in: write with sop_out=1, pix_cnt=1 -> PASS; if eop_in also set -> PAD (err_short) unless FRAME_PIX==1 (eop_out=1, -> IDLE).
  PASS: ready_out=space && !(valid_in && sop_in). Accepted beat forwarded, pix_cnt++.
    - beat with pix_cnt==FRAME_PIX-1: written with eop_out=1, frame_done; eop_in -> IDLE, else -> DROP and set err_long.
    - eop_in earlier: written with eop_out=0, -> PAD, set err_short.
    - valid_in && sop_in mid-frame: beat not accepted (held upstream), -> PAD, set err_short.
  PAD: ready_out=0; each cycle with space write PAD_COLOR, pix_cnt++; last beat eop_out=1, frame_done, -> IDLE.
  DROP: ready_out=1 discard; accepted eop_in -> IDLE; valid_in && sop_in -> IDLE without accepting (IDLE then takes it).
- pix_cnt resets to 0 on every return to IDLE.
- clear_err and a new error in same cycle: error wins (flag stays 1).
- Skid full with ready_in=0 indefinitely: ready_out=0 in PASS, PAD halts; no beat lost or duplicated.

Optional Feature:
FRAME_ALIGNER_STATS_EN: when defined, adds outputs frame_cnt[15:0] (increments on each frame_done, wraps 16'hFFFF->0, reset 0) and err_cnt[7:0] (increments on each short/long event, saturates at 8'hFF, cleared by clear_err). When undefined, ports and logic absent; core behaviour identical.

Decomposition:
- Package video_pkg: state enum (IDLE, PASS, PAD, DROP), pixel typedef logic [DATA_W-1:0], beat struct {data, sop, eop}.
- Sub-module video_skid_buffer: 2-entry Avalon-ST register slice (in: wr_valid/beat, out: space; source side valid/ready); reused elsewhere in the pipeline.

Test Plan:
(H_RES=4, V_RES=2, FRAME_PIX=8, PAD_COLOR=16'hF800)
- Clean frame 8 beats 0x0001..0x0008, sop/eop correct, ready_in=1 -> identical 8 beats out, 1-cycle latency, frame_done once, no error flags.
- Short frame: eop_in on beat 5 -> beats 1..5 passed, 3 beats 16'hF800, eop_out on 8th, err_short=1.
- Long frame: 11 beats, eop_in on 11th -> 8 beats out with eop_out on 8th, beats 9..11 discarded with ready_out=1, err_long=1.
- Beats without sop after reset, then proper frame -> garbage discarded, only framed 8 beats out.
- Random ready_in back-pressure (50%) on clean frames -> output sequence matches input exactly, data stable while stalled.
- Mid-frame sop at beat 4 -> 3 beats + 5 pads emitted, then new frame starts with sop beat; reset asserted mid-frame -> all outputs 0 immediately, next sop frame clean.
